// File: rtl/param_shift_engine_if.sv
// Bus interface for param_shift_engine: load, shift and burst controls in, register view out.
interface param_shift_engine_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
);
  logic             LOAD;
  logic [WIDTH-1:0] DATA;
  logic             SHIFT;
  logic             DIR;
  logic [1:0]       MODE;
  logic             SER_IN;
  logic             START;
  logic [CNT_W-1:0] COUNT;
  logic [WIDTH-1:0] Q;
  logic             SER_OUT;
  logic             BUSY;
  logic             DONE;

  modport master (
    output LOAD, DATA, SHIFT, DIR, MODE, SER_IN, START, COUNT,
    input  Q, SER_OUT, BUSY, DONE
  );

  modport slave (
    input  LOAD, DATA, SHIFT, DIR, MODE, SER_IN, START, COUNT,
    output Q, SER_OUT, BUSY, DONE
  );
endinterface

// File: rtl/param_shift_engine.sv
// Shift register with logical/rotate/arithmetic single steps and counted bursts.
// Bursts latch direction and mode at START; LOAD aborts a burst without a DONE pulse.
module param_shift_engine #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 4
) (
  input logic                CLK,
  input logic                RST,
  param_shift_engine_if.slave bus
);

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;
  logic [1:0]         mode_q, mode_d;
  logic               done_q, done_d;

  function automatic logic [WIDTH-1:0] step_fn(input logic [WIDTH-1:0] q, input logic dir,
                                               input logic [1:0] mode, input logic ser);
    logic [WIDTH-1:0] r;
    case (mode)
      2'b01:   r = dir ? {q[WIDTH-2:0], q[WIDTH-1]} : {q[0], q[WIDTH-1:1]};
      2'b10:   r = dir ? {q[WIDTH-2:0], 1'b0} : {q[WIDTH-1], q[WIDTH-1:1]};
      default: r = dir ? {q[WIDTH-2:0], ser} : {ser, q[WIDTH-1:1]};
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    done_d  = 1'b0;
    if (bus.LOAD) begin
      q_d     = bus.DATA;
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.START) begin
            if (bus.COUNT != '0) begin
              cnt_d   = bus.COUNT;
              dir_d   = bus.DIR;
              mode_d  = bus.MODE;
              state_d = StRun;
            end else begin
              done_d = 1'b1;
            end
          end else if (bus.SHIFT) begin
            q_d = step_fn(q_q, bus.DIR, bus.MODE, bus.SER_IN);
          end
        end
        StRun: begin
          // Serial fill stays live during a burst; only direction and mode are latched.
          q_d = step_fn(q_q, dir_q, mode_q, bus.SER_IN);
          if (cnt_q == CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = StIdle;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= StIdle;
      q_q     <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= 2'b00;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
    end
  end

  logic eff_dir;
  assign eff_dir     = (state_q == StRun) ? dir_q : bus.DIR;
  assign bus.Q       = q_q;
  assign bus.SER_OUT = eff_dir ? q_q[WIDTH-1] : q_q[0];
  assign bus.BUSY    = (state_q == StRun);
  assign bus.DONE    = done_q;

endmodule

// File: tb/tb_param_shift_engine.sv
// Directed bench for param_shift_engine (WIDTH=8, CNT_W=4) with immediate-assertion checks.
module tb_param_shift_engine;
  logic CLK = 1'b0;
  logic RST;
  int   checks = 0;
  int   errors = 0;

  param_shift_engine_if #(.WIDTH(8), .CNT_W(4)) bus ();

  param_shift_engine #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    RST = 1'b1;
    bus.LOAD = 1'b1; bus.DATA = 8'hFF; bus.SHIFT = 1'b0; bus.DIR = 1'b0;
    bus.MODE = 2'b00; bus.SER_IN = 1'b0; bus.START = 1'b0; bus.COUNT = 4'd0;
    tick();
    check("rst_q", 32'(bus.Q), 32'h00);
    check("rst_busy", 32'(bus.BUSY), 0);
    check("rst_done", 32'(bus.DONE), 0);

    // Logical left step
    RST = 1'b0; bus.DATA = 8'hA5;
    tick();
    check("load_a5", 32'(bus.Q), 32'hA5);
    bus.LOAD = 1'b0; bus.SHIFT = 1'b1; bus.DIR = 1'b1; bus.MODE = 2'b00; bus.SER_IN = 1'b1;
    #1 check("serout_left_a5", 32'(bus.SER_OUT), 1);
    tick();
    check("lsl_4b", 32'(bus.Q), 32'h4B);
    check("serout_left_4b", 32'(bus.SER_OUT), 0);

    // Arithmetic right, two steps
    bus.SHIFT = 1'b0; bus.LOAD = 1'b1; bus.DATA = 8'h90;
    tick();
    bus.LOAD = 1'b0; bus.SHIFT = 1'b1; bus.DIR = 1'b0; bus.MODE = 2'b10; bus.SER_IN = 1'b0;
    tick();
    check("asr_c8", 32'(bus.Q), 32'hC8);
    tick();
    check("asr_e4", 32'(bus.Q), 32'hE4);

    // Rotate-right burst of 3; live DIR/MODE/SHIFT changed during RUN must not matter
    bus.SHIFT = 1'b0; bus.LOAD = 1'b1; bus.DATA = 8'h81;
    tick();
    bus.LOAD = 1'b0; bus.START = 1'b1; bus.COUNT = 4'd3; bus.DIR = 1'b0; bus.MODE = 2'b01;
    tick();
    check("burst_start_q", 32'(bus.Q), 32'h81);
    check("burst_start_busy", 32'(bus.BUSY), 1);
    check("burst_start_done", 32'(bus.DONE), 0);
    bus.START = 1'b0; bus.DIR = 1'b1; bus.MODE = 2'b00; bus.SHIFT = 1'b1;
    #1 check("serout_latched_dir", 32'(bus.SER_OUT), 1);
    tick();
    check("ror_c0", 32'(bus.Q), 32'hC0);
    check("ror_c0_busy", 32'(bus.BUSY), 1);
    tick();
    check("ror_60", 32'(bus.Q), 32'h60);
    check("ror_60_done", 32'(bus.DONE), 0);
    tick();
    check("ror_30", 32'(bus.Q), 32'h30);
    check("ror_end_busy", 32'(bus.BUSY), 0);
    check("ror_end_done", 32'(bus.DONE), 1);
    bus.SHIFT = 1'b0;
    tick();
    check("ror_hold_q", 32'(bus.Q), 32'h30);
    check("ror_done_drop", 32'(bus.DONE), 0);

    // Burst abort by LOAD on the second RUN edge
    bus.START = 1'b1; bus.COUNT = 4'd5; bus.DIR = 1'b1; bus.MODE = 2'b00; bus.SER_IN = 1'b0;
    tick();
    bus.START = 1'b0;
    tick();
    check("abort_step1", 32'(bus.Q), 32'h60);
    bus.LOAD = 1'b1; bus.DATA = 8'h3C;
    tick();
    check("abort_q", 32'(bus.Q), 32'h3C);
    check("abort_busy", 32'(bus.BUSY), 0);
    check("abort_done", 32'(bus.DONE), 0);
    bus.LOAD = 1'b0;
    tick();
    check("abort_done_after", 32'(bus.DONE), 0);
    check("abort_hold_q", 32'(bus.Q), 32'h3C);

    // Zero-count START
    bus.START = 1'b1; bus.COUNT = 4'd0;
    tick();
    check("zero_q", 32'(bus.Q), 32'h3C);
    check("zero_busy", 32'(bus.BUSY), 0);
    check("zero_done", 32'(bus.DONE), 1);
    bus.START = 1'b0;
    tick();
    check("zero_done_drop", 32'(bus.DONE), 0);

    // Mid-burst reset
    bus.START = 1'b1; bus.COUNT = 4'd4; bus.DIR = 1'b0; bus.MODE = 2'b00; bus.SER_IN = 1'b0;
    tick();
    bus.START = 1'b0;
    tick();
    check("mid_step1", 32'(bus.Q), 32'h1E);
    RST = 1'b1;
    tick();
    check("midrst_q", 32'(bus.Q), 32'h00);
    check("midrst_busy", 32'(bus.BUSY), 0);
    check("midrst_done", 32'(bus.DONE), 0);
    RST = 1'b0;
    tick();
    check("midrst_done_after", 32'(bus.DONE), 0);

    // COUNT > WIDTH: 9 left rotates of 0x81 wrap to 0x03
    bus.LOAD = 1'b1; bus.DATA = 8'h81;
    tick();
    bus.LOAD = 1'b0; bus.START = 1'b1; bus.COUNT = 4'd9; bus.DIR = 1'b1; bus.MODE = 2'b01;
    tick();
    bus.START = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check("long_busy_before_end", 32'(bus.BUSY), 1);
    tick();
    check("long_rol_q", 32'(bus.Q), 32'h03);
    check("long_done", 32'(bus.DONE), 1);
    check("long_busy", 32'(bus.BUSY), 0);

    // Mode 11 behaves as logical: right shift with SER_IN=1
    bus.SHIFT = 1'b1; bus.DIR = 1'b0; bus.MODE = 2'b11; bus.SER_IN = 1'b1;
    tick();
    check("mode11_shr", 32'(bus.Q), 32'h81);
    bus.SHIFT = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_shift_engine.md
PARAM_SHIFT_ENGINE -- requirements
Module: param_shift_engine

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the shift register width in bits (legal range 2 or more).
REQ-002 The block SHALL have parameter CNT_W, default 4, giving the width of the burst count (2**CNT_W-1 is the largest burst).
REQ-003 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-004 The block SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port LOAD, input, 1 bit: parallel load request.
REQ-006 The block SHALL have port DATA, input, WIDTH bits: parallel load value.
REQ-007 The block SHALL have port SHIFT, input, 1 bit: single-step shift request, one step per cycle while held.
REQ-008 The block SHALL have port DIR, input, 1 bit: 1 = shift left (toward MSB), 0 = shift right.
REQ-009 The block SHALL have port MODE, input, 2 bits: 00 = logical with SER_IN fill, 01 = rotate, 10 = arithmetic, 11 = same as 00.
REQ-010 The block SHALL have port SER_IN, input, 1 bit: serial fill bit (LSB on left shift, MSB on right shift).
REQ-011 The block SHALL have port START, input, 1 bit: burst start request.
REQ-012 The block SHALL have port COUNT, input, CNT_W bits: number of steps in a burst.
REQ-013 The block SHALL have port Q, output, WIDTH bits: register contents.
REQ-014 The block SHALL have port SER_OUT, output, 1 bit: the bit shifted out by the next step (Q[WIDTH-1] if the effective direction is left, else Q[0]); combinational from state.
REQ-015 The block SHALL have port BUSY, output, 1 bit: high while a burst is running.
REQ-016 The block SHALL have port DONE, output, 1 bit: one-cycle pulse when a burst completes.

Function
REQ-017 Step rules SHALL be as follows.
- MODE 00: left gives {Q[W-2:0],SER_IN}; right gives {SER_IN,Q[W-1:1]}.
- MODE 01: left gives {Q[W-2:0],Q[W-1]}; right gives {Q[0],Q[W-1:1]}.
- MODE 10: left gives {Q[W-2:0],1'b0}; right gives {Q[W-1],Q[W-1:1]}.
- MODE 10 ignores SER_IN.
REQ-018 The FSM SHALL have two states: IDLE and RUN; BUSY = (state == RUN).
REQ-019 Priority each edge SHALL be RST > LOAD > START (IDLE only) > SHIFT (IDLE only) > hold.
REQ-020 In IDLE, a sampled LOAD SHALL give Q <= DATA.
REQ-021 In IDLE, a sampled SHIFT SHALL apply one step using the live DIR and MODE.
REQ-022 In IDLE, START with COUNT = N > 0 SHALL latch DIR, MODE and N, move to RUN, and leave Q unchanged on that edge.
REQ-023 In RUN, each edge SHALL apply one step using the latched DIR/MODE and the live SER_IN, then decrement the remaining count.
REQ-024 The edge that applies step N SHALL return the FSM to IDLE and set DONE = 1 for exactly the following cycle.
REQ-025 Burst timing SHALL be: START sampled at edge k gives steps at edges k+1..k+N, BUSY high from edge k to edge k+N, and DONE high between edges k+N and k+N+1.
REQ-026 START with COUNT = 0 SHALL stay in IDLE, leave Q unchanged, and pulse DONE for one cycle after that edge.
REQ-027 COUNT > WIDTH SHALL be legal; steps SHALL continue, so a rotate wraps and a logical shift fully flushes.
REQ-028 In RUN, START and SHIFT SHALL be ignored.
REQ-029 LOAD in RUN SHALL abort the burst: Q <= DATA, FSM returns to IDLE, and no DONE pulse.
REQ-030 In RUN, SER_OUT SHALL use the latched DIR; in IDLE it SHALL use the live DIR.
REQ-031 DONE SHALL never be asserted in a cycle in which BUSY is high.

Reset
REQ-032 RST sampled high SHALL set Q = 0, state = IDLE, BUSY = 0, DONE = 0, and clear the remaining count and latched DIR/MODE.
REQ-033 RST SHALL override LOAD, START and SHIFT on the same edge.
REQ-034 RST mid-burst SHALL abort the burst with no DONE pulse.
REQ-035 No state SHALL change asynchronously on RST.

Verification (WIDTH = 8, CNT_W = 4)
REQ-036 Reset scenario:
- Stimulus: RST high for 1 edge while LOAD = 1 and DATA = 8'hFF.
- Required response: Q = 8'h00, BUSY = 0, DONE = 0.
REQ-037 Logical left step scenario:
- Stimulus: LOAD 8'hA5, then SHIFT with DIR = 1, MODE = 00, SER_IN = 1 for 1 edge.
- Required response: Q = 8'h4B.
REQ-038 Arithmetic right scenario:
- Stimulus: LOAD 8'h90, then SHIFT with DIR = 0, MODE = 10 for 2 edges.
- Required response: Q = 8'hC8 then 8'hE4.
REQ-039 Rotate-right burst scenario:
- Stimulus: LOAD 8'h81, then START with COUNT = 3, DIR = 0, MODE = 01.
- Required response: Q = C0, 60, 30 on successive edges; BUSY high for 3 cycles; DONE high for 1 cycle after the third step; Q stays 8'h30.
REQ-040 Burst abort scenario:
- Stimulus: START with COUNT = 5, then LOAD 8'h3C on the second RUN edge.
- Required response: Q = 8'h3C, BUSY = 0 on the next cycle, DONE never asserted.
REQ-041 Zero-count and mid-burst reset scenario:
- Stimulus: START with COUNT = 0.
- Required response: Q unchanged, BUSY stays 0, DONE pulses once.
- Stimulus: START with COUNT = 4, then RST on the second RUN edge.
- Required response: Q = 0, BUSY = 0, no DONE.
